// File: rtl/pam4_tx_sequencer.sv
// PAM-4 transmit sequencer: frames a preamble of alternating outer levels followed by
// payload bytes serialised MSB-first as 2-bit symbols for the PAM-4 encoder.
module pam4_tx_sequencer #(
    parameter int PREAMBLE_LEN = 16,
    parameter int FRAME_BYTES  = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  byte_in,
    input  logic        byte_in_valid,
    output logic        byte_in_ready,
    output logic [1:0]  symbol_out,
    output logic        symbol_out_valid,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] underrun_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        PAYLOAD  = 2'd2
    } state_t;

    localparam logic [7:0] PRE_LAST    = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0] BYTES_TOTAL = 8'(FRAME_BYTES);

    state_t      state_q, state_d;
    logic [7:0]  pre_cnt_q, pre_cnt_d;
    logic [7:0]  acc_cnt_q, acc_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        full_q, full_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  sym_q, sym_d;
    logic        sym_valid_q, sym_valid_d;
    logic        done_q, done_d;
    logic [15:0] underrun_q, underrun_d;
    logic        byte_accept;

    // A new byte may enter while the register is empty, or on the edge that shifts
    // out the last symbol of the current byte so payload stays gap-free.
    assign byte_in_ready = ((state_q == PREAMBLE) || (state_q == PAYLOAD)) &&
                           (acc_cnt_q < BYTES_TOTAL) &&
                           (!full_q || ((state_q == PAYLOAD) && (idx_q == 2'd3)));
    assign byte_accept   = byte_in_valid && byte_in_ready;

    assign symbol_out       = sym_q;
    assign symbol_out_valid = sym_valid_q;
    assign busy             = (state_q != IDLE);
    assign frame_done       = done_q;
    assign underrun_cnt     = underrun_q;

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        acc_cnt_d   = acc_cnt_q;
        shift_d     = shift_q;
        full_d      = full_q;
        idx_d       = idx_q;
        sym_d       = sym_q;
        sym_valid_d = 1'b0;
        done_d      = 1'b0;
        underrun_d  = underrun_q;

        if (abort) begin
            state_d   = IDLE;
            pre_cnt_d = '0;
            acc_cnt_d = '0;
            full_d    = 1'b0;
            idx_d     = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d    = PREAMBLE;
                        underrun_d = '0;
                        pre_cnt_d  = '0;
                        acc_cnt_d  = '0;
                        full_d     = 1'b0;
                        idx_d      = '0;
                    end
                end
                PREAMBLE: begin
                    sym_d       = pre_cnt_q[0] ? 2'b00 : 2'b11;
                    sym_valid_d = 1'b1;
                    if (pre_cnt_q == PRE_LAST) begin
                        state_d   = PAYLOAD;
                        pre_cnt_d = '0;
                    end else begin
                        pre_cnt_d = pre_cnt_q + 8'd1;
                    end
                    if (byte_accept) begin
                        shift_d   = byte_in;
                        full_d    = 1'b1;
                        acc_cnt_d = acc_cnt_q + 8'd1;
                        idx_d     = '0;
                    end
                end
                PAYLOAD: begin
                    if (full_q) begin
                        sym_d       = shift_q[7:6];
                        sym_valid_d = 1'b1;
                        shift_d     = {shift_q[5:0], 2'b00};
                        idx_d       = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            if (byte_accept) begin
                                shift_d   = byte_in;
                                acc_cnt_d = acc_cnt_q + 8'd1;
                            end else begin
                                full_d = 1'b0;
                            end
                            // Every byte already taken in means this was the frame's last symbol.
                            if (acc_cnt_q == BYTES_TOTAL) begin
                                done_d    = 1'b1;
                                state_d   = IDLE;
                                acc_cnt_d = '0;
                            end
                        end
                    end else begin
                        if (underrun_q != 16'hFFFF) begin
                            underrun_d = underrun_q + 16'd1;
                        end
                        if (byte_accept) begin
                            shift_d   = byte_in;
                            full_d    = 1'b1;
                            acc_cnt_d = acc_cnt_q + 8'd1;
                            idx_d     = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            pre_cnt_q   <= '0;
            acc_cnt_q   <= '0;
            shift_q     <= '0;
            full_q      <= 1'b0;
            idx_q       <= '0;
            sym_q       <= 2'b00;
            sym_valid_q <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= '0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
            shift_q     <= shift_d;
            full_q      <= full_d;
            idx_q       <= idx_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
        end
    end

endmodule

// File: tb/tb_pam4_tx_sequencer.sv
// Self-checking bench for pam4_tx_sequencer: a symbol-queue model predicts every
// output each cycle, and directed frames pin the model against hand-derived sequences.
module tb_pam4_tx_sequencer;

    localparam int PL = 4;
    localparam int FB = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_in_valid = 1'b0;
    logic        byte_in_ready;
    logic [1:0]  symbol_out;
    logic        symbol_out_valid;
    logic        busy;
    logic        frame_done;
    logic [15:0] underrun_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model: a frame is PL preamble symbols, then a queue of pending payload symbols.
    bit         m_active = 1'b0;
    int         m_pre_left = 0;
    logic [1:0] m_symq[$];
    int         m_acc = 0;
    int         m_paid = 0;
    int         m_under = 0;
    logic [1:0] m_sym = 2'b00;
    bit         m_valid = 1'b0;
    bit         m_done = 1'b0;

    logic [7:0] src_bytes[$];
    int         src_idx = 0;
    int         vmode = 0;

    bit         log_valid[$];
    logic [1:0] log_sym[$];
    bit         log_done[$];
    logic [1:0] exp_frame[$];

    pam4_tx_sequencer #(
        .PREAMBLE_LEN(PL),
        .FRAME_BYTES (FB)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .start           (start),
        .abort           (abort),
        .byte_in         (byte_in),
        .byte_in_valid   (byte_in_valid),
        .byte_in_ready   (byte_in_ready),
        .symbol_out      (symbol_out),
        .symbol_out_valid(symbol_out_valid),
        .busy            (busy),
        .frame_done      (frame_done),
        .underrun_cnt    (underrun_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit m_ready();
        return m_active && (m_acc < FB) &&
               ((m_symq.size() == 0) || ((m_pre_left == 0) && (m_symq.size() == 1)));
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_active   = 1'b0;
            m_symq.delete();
            m_acc      = 0;
            m_paid     = 0;
            m_under    = 0;
            m_sym      = 2'b00;
            m_valid    = 1'b0;
            m_done     = 1'b0;
            m_pre_left = 0;
            src_idx    = 0;
        end else begin
            bit take;
            take    = byte_in_valid && m_ready();
            m_valid = 1'b0;
            m_done  = 1'b0;
            if (abort) begin
                m_active = 1'b0;
                m_symq.delete();
                take = 1'b0;
            end else if (!m_active) begin
                if (start) begin
                    m_active   = 1'b1;
                    m_pre_left = PL;
                    m_symq.delete();
                    m_acc      = 0;
                    m_paid     = 0;
                    m_under    = 0;
                    src_idx    = 0;
                end
                take = 1'b0;
            end else if (m_pre_left > 0) begin
                m_sym      = (((PL - m_pre_left) % 2) == 0) ? 2'b11 : 2'b00;
                m_valid    = 1'b1;
                m_pre_left = m_pre_left - 1;
            end else if (m_symq.size() > 0) begin
                m_sym   = m_symq.pop_front();
                m_valid = 1'b1;
                m_paid  = m_paid + 1;
                if (m_paid == 4 * FB) begin
                    m_done   = 1'b1;
                    m_active = 1'b0;
                end
            end else if (m_under < 65535) begin
                m_under = m_under + 1;
            end
            if (take) begin
                m_symq.push_back(byte_in[7:6]);
                m_symq.push_back(byte_in[5:4]);
                m_symq.push_back(byte_in[3:2]);
                m_symq.push_back(byte_in[1:0]);
                m_acc   = m_acc + 1;
                src_idx = src_idx + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Vmode 2 withholds data exactly while the second byte is wanted and two bubbles have not yet elapsed.
    task automatic applyStimulus();
        bit v;
        case (vmode)
            0:       v = 1'b1;
            1:       v = ($urandom_range(0, 3) != 0);
            default: v = !((m_acc == 1) && m_ready() && (m_under < 2));
        endcase
        if (src_idx >= src_bytes.size()) v = 1'b0;
        byte_in_valid = v;
        byte_in       = v ? src_bytes[src_idx] : 8'($urandom);
    endtask

    task automatic stepCycle();
        @(negedge clk);
        checkOutput("symbol_out", {30'd0, symbol_out}, {30'd0, m_sym});
        checkOutput("symbol_out_valid", {31'd0, symbol_out_valid}, {31'd0, m_valid});
        checkOutput("frame_done", {31'd0, frame_done}, {31'd0, m_done});
        checkOutput("busy", {31'd0, busy}, {31'd0, m_active});
        checkOutput("underrun_cnt", {16'd0, underrun_cnt}, 32'(m_under));
        checkOutput("byte_in_ready", {31'd0, byte_in_ready}, {31'd0, m_ready()});
        log_valid.push_back(symbol_out_valid);
        log_sym.push_back(symbol_out);
        log_done.push_back(frame_done);
        applyStimulus();
    endtask

    task automatic waitDone(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            stepCycle();
            if (log_done[log_done.size() - 1]) begin
                at = log_done.size() - 1;
                break;
            end
        end
        checkOutput("frame_done_seen", {31'd0, (at >= 0)}, 32'd1);
    endtask

    // Scans the log from the start-sampling entry to the present against exp_frame.
    task automatic checkFrameLog(input string name, input int from, input int exp_bubbles);
        int first, last, dones, done_at, bubbles, before_bubble, nvalid;
        logic [1:0] got[$];
        first = -1; last = -1; dones = 0; done_at = -1;
        bubbles = 0; before_bubble = -1; nvalid = 0;
        for (int i = from; i < log_valid.size(); i++) begin
            if (log_valid[i]) begin
                if (first < 0) first = i;
                last = i;
                got.push_back(log_sym[i]);
            end
            if (log_done[i]) begin
                dones++;
                done_at = i;
            end
        end
        for (int i = first; (first >= 0) && (i <= last); i++) begin
            if (log_valid[i]) begin
                nvalid++;
            end else begin
                if (before_bubble < 0) before_bubble = nvalid;
                bubbles++;
            end
        end
        checkOutput($sformatf("%s_latency", name), 32'(first), 32'(from + 1));
        checkOutput($sformatf("%s_count", name), 32'(got.size()), 32'(exp_frame.size()));
        for (int k = 0; (k < got.size()) && (k < exp_frame.size()); k++) begin
            checkOutput($sformatf("%s_sym%0d", name, k), {30'd0, got[k]}, {30'd0, exp_frame[k]});
        end
        checkOutput($sformatf("%s_done_count", name), 32'(dones), 32'd1);
        checkOutput($sformatf("%s_done_on_last", name), 32'(done_at), 32'(last));
        checkOutput($sformatf("%s_bubbles", name), 32'(bubbles), 32'(exp_bubbles));
        if (exp_bubbles > 0) begin
            checkOutput($sformatf("%s_bubble_pos", name), 32'(before_bubble), 32'd8);
        end
    endtask

    task automatic runFrame(input string name, input int exp_bubbles);
        int mark, done_at;
        mark  = log_valid.size();
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        waitDone(40, done_at);
        stepCycle();
        checkFrameLog(name, mark, exp_bubbles);
        checkOutput($sformatf("%s_underrun", name), {16'd0, underrun_cnt}, 32'(exp_bubbles));
        checkOutput($sformatf("%s_idle_after", name), {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int mark, d1, d2, gap, dones;
        exp_frame = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00,
                      2'b00, 2'b01, 2'b11, 2'b10};
        #2 rstn = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("reset_symbol_out", {30'd0, symbol_out}, 32'd0);
        checkOutput("reset_valid", {31'd0, symbol_out_valid}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, frame_done}, 32'd0);
        checkOutput("reset_underrun", {16'd0, underrun_cnt}, 32'd0);
        checkOutput("reset_ready", {31'd0, byte_in_ready}, 32'd0);
        rstn = 1'b1;
        stepCycle();

        src_bytes = '{8'hB4, 8'h1E};
        vmode = 0;
        runFrame("basic", 0);

        vmode = 2;
        runFrame("bubble", 3);

        // Abort while the third payload symbol is on the output.
        vmode = 0;
        mark  = log_valid.size();
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            int nv;
            nv = 0;
            for (int k = mark; k < log_valid.size(); k++) nv += int'(log_valid[k]);
            if (nv == PL + 3) break;
            stepCycle();
        end
        checkOutput("abort_at_sym3", {30'd0, symbol_out}, 32'h1);
        abort = 1'b1;
        stepCycle();
        abort = 1'b0;
        checkOutput("abort_valid", {31'd0, symbol_out_valid}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_ready", {31'd0, byte_in_ready}, 32'd0);
        stepCycle();
        stepCycle();
        dones = 0;
        for (int k = mark; k < log_done.size(); k++) dones += int'(log_done[k]);
        checkOutput("abort_no_done", 32'(dones), 32'd0);
        runFrame("after_abort", 0);

        // Asynchronous reset in the middle of the preamble.
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("pre_reset_sym", {30'd0, symbol_out}, 32'h3);
        #2 rstn = 1'b0;
        #1;
        checkOutput("async_symbol_out", {30'd0, symbol_out}, 32'd0);
        checkOutput("async_valid", {31'd0, symbol_out_valid}, 32'd0);
        checkOutput("async_busy", {31'd0, busy}, 32'd0);
        checkOutput("async_ready", {31'd0, byte_in_ready}, 32'd0);
        start = 1'b1;
        stepCycle();
        stepCycle();
        checkOutput("reset_ignores_start", {31'd0, busy}, 32'd0);
        start = 1'b0;
        rstn  = 1'b1;
        stepCycle();
        stepCycle();
        checkOutput("no_resume_busy", {31'd0, busy}, 32'd0);
        checkOutput("no_resume_valid", {31'd0, symbol_out_valid}, 32'd0);

        // Start held high across two frames.
        mark  = log_valid.size();
        start = 1'b1;
        stepCycle();
        waitDone(40, d1);
        checkFrameLog("b2b_first", mark, 0);
        waitDone(40, d2);
        start = 1'b0;
        gap = -1;
        for (int i = d1 + 1; (i < log_valid.size()) && (gap < 0); i++) begin
            if (log_valid[i]) gap = i - d1 - 1;
        end
        checkOutput("b2b_gap", 32'(gap), 32'd1);
        if (d1 >= 0) checkFrameLog("b2b_second", d1 + 1, 0);
        stepCycle();
        stepCycle();

        // Randomised frames with random data gaps, aborts, stray starts and resets.
        vmode = 1;
        for (int f = 0; f < 60; f++) begin
            src_bytes.delete();
            for (int b = 0; b < FB; b++) src_bytes.push_back(8'($urandom));
            repeat ($urandom_range(0, 3)) stepCycle();
            start = 1'b1;
            stepCycle();
            start = 1'b0;
            for (int c = 0; (c < 200) && busy; c++) begin
                start = ($urandom_range(0, 7) == 0);
                abort = ($urandom_range(0, 59) == 0);
                if ($urandom_range(0, 299) == 0) begin
                    #1 rstn = 1'b0;
                    #1 rstn = 1'b1;
                end
                stepCycle();
            end
            start = 1'b0;
            abort = 1'b0;
            stepCycle();
            stepCycle();
            checkOutput("random_frame_ends", {31'd0, busy}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
